// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle main FSM and its datapath.
// The controller takes the master side; the datapath/memory takes the slave side.
interface multicycle_control_if;
   logic [6:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        mem_read;
   logic        mem_write;
   logic        iord;
   logic        ir_write;
   logic        pc_write;
   logic        pc_source;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  alu_op;
   logic        reg_write;
   logic        mem_to_reg;
   logic        illegal_instr;
   logic [3:0]  state;
   logic [31:0] retired;

   modport master (
      input  opcode,
      input  zero,
      input  mem_ready,
      output mem_read,
      output mem_write,
      output iord,
      output ir_write,
      output pc_write,
      output pc_source,
      output alu_src_a,
      output alu_src_b,
      output alu_op,
      output reg_write,
      output mem_to_reg,
      output illegal_instr,
      output state,
      output retired
   );

   modport slave (
      output opcode,
      output zero,
      output mem_ready,
      input  mem_read,
      input  mem_write,
      input  iord,
      input  ir_write,
      input  pc_write,
      input  pc_source,
      input  alu_src_a,
      input  alu_src_b,
      input  alu_op,
      input  reg_write,
      input  mem_to_reg,
      input  illegal_instr,
      input  state,
      input  retired
   );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V datapath (lb/sb/add/and/sll/ori/bne).
// Moore outputs except ir_write/pc_write in FETCH and pc_write in BRANCH.
module multicycle_control #(
   parameter logic [6:0] OPC_R      = 7'b0110011,
   parameter logic [6:0] OPC_LOAD   = 7'b0000011,
   parameter logic [6:0] OPC_STORE  = 7'b0100011,
   parameter logic [6:0] OPC_IMM    = 7'b0010011,
   parameter logic [6:0] OPC_BRANCH = 7'b1100011
) (
   input logic                  clk,
   input logic                  rst_n,
   multicycle_control_if.master bus
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MADDR  = 4'd2;
   localparam logic [3:0] S_MRD    = 4'd3;
   localparam logic [3:0] S_MWB    = 4'd4;
   localparam logic [3:0] S_MWR    = 4'd5;
   localparam logic [3:0] S_EXR    = 4'd6;
   localparam logic [3:0] S_EXI    = 4'd7;
   localparam logic [3:0] S_AWB    = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_TRAP   = 4'd10;

   logic [3:0]  state_q, state_d;
   logic [31:0] retired_q, retired_d;

   logic op_load, op_store, op_r, op_imm, op_br;
   logic retire;

   logic       mem_read_c, mem_write_c;
   logic       ir_write_c, pc_write_c;
   logic       reg_write_c, illegal_c;
   logic       iord_c, pc_source_c, mem_to_reg_c;
   logic [1:0] alu_src_a_c, alu_src_b_c;
   logic [2:0] alu_op_c;

   assign op_load  = (bus.opcode == OPC_LOAD);
   assign op_store = (bus.opcode == OPC_STORE);
   assign op_r     = (bus.opcode == OPC_R);
   assign op_imm   = (bus.opcode == OPC_IMM);
   assign op_br    = (bus.opcode == OPC_BRANCH);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:
            if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               op_load,
               op_store: state_d = S_MADDR;
               op_r:     state_d = S_EXR;
               op_imm:   state_d = S_EXI;
               op_br:    state_d = S_BRANCH;
               default:  state_d = S_TRAP;
            endcase
         end
         S_MADDR: begin
            unique case (1'b1)
               op_load:  state_d = S_MRD;
               op_store: state_d = S_MWR;
               default:  state_d = S_FETCH;
            endcase
         end
         S_MRD:
            if (bus.mem_ready) state_d = S_MWB;
         S_MWB:    state_d = S_FETCH;
         S_MWR:
            if (bus.mem_ready) state_d = S_FETCH;
         S_EXR:    state_d = S_AWB;
         S_EXI:    state_d = S_AWB;
         S_AWB:    state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_TRAP:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      mem_read_c   = 1'b0;
      mem_write_c  = 1'b0;
      iord_c       = 1'b0;
      ir_write_c   = 1'b0;
      pc_write_c   = 1'b0;
      pc_source_c  = 1'b0;
      alu_src_a_c  = 2'b00;
      alu_src_b_c  = 2'b00;
      alu_op_c     = 3'b000;
      reg_write_c  = 1'b0;
      mem_to_reg_c = 1'b0;
      illegal_c    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_c  = 1'b1;
            alu_src_b_c = 2'b01;
            ir_write_c  = bus.mem_ready;
            pc_write_c  = bus.mem_ready;
         end
         // branch target PC+imm parked in ALUOut
         S_DECODE: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b10;
         end
         S_MADDR: begin
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b10;
         end
         S_MRD: begin
            mem_read_c = 1'b1;
            iord_c     = 1'b1;
         end
         S_MWB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = 1'b1;
         end
         S_MWR: begin
            mem_write_c = 1'b1;
            iord_c      = 1'b1;
         end
         S_EXR: begin
            alu_src_a_c = 2'b01;
            alu_op_c    = 3'b010;
         end
         S_EXI: begin
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b10;
            alu_op_c    = 3'b011;
         end
         S_AWB:
            reg_write_c = 1'b1;
         S_BRANCH: begin
            alu_src_a_c = 2'b01;
            alu_op_c    = 3'b001;
            pc_source_c = 1'b1;
            pc_write_c  = ~bus.zero;
         end
         S_TRAP:
            illegal_c = 1'b1;
         default: ;
      endcase
   end

   assign retire = (state_q == S_MWB)
                 | (state_q == S_AWB)
                 | (state_q == S_BRANCH)
                 | ((state_q == S_MWR) & bus.mem_ready);

   assign retired_d = retire ? retired_q + 32'd1 : retired_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // strobes are held off for the whole reset window, not just at the edge
   assign bus.mem_read      = rst_n & mem_read_c;
   assign bus.mem_write     = rst_n & mem_write_c;
   assign bus.ir_write      = rst_n & ir_write_c;
   assign bus.pc_write      = rst_n & pc_write_c;
   assign bus.reg_write     = rst_n & reg_write_c;
   assign bus.illegal_instr = rst_n & illegal_c;

   assign bus.iord       = iord_c;
   assign bus.pc_source  = pc_source_c;
   assign bus.alu_src_a  = alu_src_a_c;
   assign bus.alu_src_b  = alu_src_b_c;
   assign bus.alu_op     = alu_op_c;
   assign bus.mem_to_reg = mem_to_reg_c;
   assign bus.state      = state_q;
   assign bus.retired    = retired_q;

endmodule
